// File: rtl/ascon_round_sequencer.sv
// ascon_round_sequencer: start/done round loop controller issuing ASCON round enables, constants and indices
module ascon_round_sequencer #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       abort_i,
  output logic       round_en_o,
  output logic [7:0] round_const_o,
  output logic [3:0] round_idx_o,
  output logic       last_round_o,
  output logic       busy_o,
  output logic       done_o
);
  if (ROUNDS_A < 1 || ROUNDS_A > 12 || ROUNDS_B < 1 || ROUNDS_B > 12) begin : g_bad_params
    $error("ascon_round_sequencer: ROUNDS_A and ROUNDS_B must lie in 1..12");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] IDX_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] IDX_B = 4'(12 - ROUNDS_B);
  state_t     state;
  logic [3:0] idx;
  logic       run;
  always_ff @(posedge clock_i or negedge resetb_i)
    if (!resetb_i) begin
      state <= IDLE;
      idx   <= '0;
    end else if (abort_i) begin
      state <= IDLE;
      idx   <= '0;
    end else
      case (state)
        IDLE: if (start_i) begin
          state <= RUN;
          idx   <= mode_i ? IDX_B : IDX_A;
        end
        RUN:  if (idx == 4'd11) state <= DONE;
              else idx <= idx + 4'd1;
        DONE: begin
          state <= IDLE;
          idx   <= '0;
        end
        default: state <= IDLE;
      endcase
  // every output is a pure decode of state and idx
  always_comb begin
    run           = state == RUN;
    round_en_o    = run;
    round_idx_o   = run ? idx : 4'd0;
    round_const_o = run ? {4'hF - idx, idx} : 8'h00;
    last_round_o  = run && idx == 4'd11;
    busy_o        = state != IDLE;
    done_o        = state == DONE;
  end
endmodule

// File: tb/tb_ascon_round_sequencer.sv
// tb_ascon_round_sequencer: scoreboard bench over three parameter sets of ascon_round_sequencer
module tb_ascon_round_sequencer;
  typedef struct {
    int          cyc;
    logic [15:0] out;
  } item_t;
  localparam logic [7:0] RC [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                     8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  logic       clk = 1'b0;
  logic       resetb = 1'b1;
  logic       start_s [3];
  logic       mode_s  [3];
  logic       abort_s [3];
  logic       en      [3];
  logic [7:0] rc      [3];
  logic [3:0] ix      [3];
  logic       last    [3];
  logic       busy    [3];
  logic       dn      [3];
  item_t      q [3][$];
  int         cyc = 0;
  int         nvec = 0;
  int         nerr = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    ascon_round_sequencer #(
      .ROUNDS_A(g == 2 ? 1 : 12),
      .ROUNDS_B(g == 1 ? 8 : 6)
    ) u_dut (
      .clock_i      (clk),
      .resetb_i     (resetb),
      .start_i      (start_s[g]),
      .mode_i       (mode_s[g]),
      .abort_i      (abort_s[g]),
      .round_en_o   (en[g]),
      .round_const_o(rc[g]),
      .round_idx_o  (ix[g]),
      .last_round_o (last[g]),
      .busy_o       (busy[g]),
      .done_o       (dn[g])
    );
  end
  function automatic logic [15:0] obs(input int d);
    return {en[d], rc[d], ix[d], last[d], busy[d], dn[d]};
  endfunction
  // rounds 0..n-1 of an r-round run accepted at the edge ending cycle c, optionally followed by done
  task automatic expect_run(input int d, input int c, input int r, input int n, input bit with_done);
    for (int k = 0; k < n; k++) begin
      int i;
      i = 12 - r + k;
      q[d].push_back('{c + 1 + k, {1'b1, RC[i], 4'(i), k == r - 1, 1'b1, 1'b0}});
    end
    if (with_done) q[d].push_back('{c + r + 1, 16'h0003});
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask
  task automatic kick(input int d, input bit m);
    start_s[d] = 1'b1;
    mode_s[d]  = m;
  endtask
  always @(negedge clk)
    for (int d = 0; d < 3; d++) begin
      logic [15:0] o;
      item_t       e;
      o = obs(d);
      nvec++;
      if (en[d] || dn[d]) begin
        if (q[d].size() == 0) begin
          nerr++;
          $display("FAIL unexpected_output dut%0d cycle %0d got %h required none", d, cyc, o);
        end else begin
          e = q[d].pop_front();
          if (e.cyc != cyc || e.out != o) begin
            nerr++;
            $display("FAIL round_output dut%0d got cycle %0d out %h required cycle %0d out %h",
                     d, cyc, o, e.cyc, e.out);
          end
        end
      end else if (o != 16'h0) begin
        nerr++;
        $display("FAIL idle_outputs dut%0d cycle %0d got %h required 0000", d, cyc, o);
      end
    end
  initial begin
    int c;
    for (int d = 0; d < 3; d++) begin
      start_s[d] = 1'b0;
      mode_s[d]  = 1'b0;
      abort_s[d] = 1'b0;
    end
    #1 resetb = 1'b0;
    wait_cycles(3);
    resetb = 1'b1;
    wait_cycles(2);
    // p^a on dut0, p^b with 8 rounds on dut1, single-round p^a on dut2
    c = cyc;
    kick(0, 1'b0); kick(1, 1'b1); kick(2, 1'b0);
    expect_run(0, c, 12, 12, 1);
    expect_run(1, c, 8, 8, 1);
    expect_run(2, c, 1, 1, 1);
    tick();
    for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
    wait_cycles(15);
    c = cyc;
    kick(0, 1'b1);
    expect_run(0, c, 6, 6, 1);
    tick();
    start_s[0] = 1'b0;
    wait_cycles(10);
    // start re-asserted during RUN and DONE with mode toggling
    c = cyc;
    kick(0, 1'b0);
    expect_run(0, c, 12, 12, 1);
    for (int k = 1; k <= 13; k++) begin
      tick();
      start_s[0] = k >= 2;
      mode_s[0]  = k[0];
    end
    tick();
    start_s[0] = 1'b0;
    mode_s[0]  = 1'b0;
    wait_cycles(5);
    // start held: back-to-back runs with period R+2
    c = cyc;
    kick(0, 1'b1);
    expect_run(0, c, 6, 6, 1);
    expect_run(0, c + 8, 6, 6, 1);
    expect_run(0, c + 16, 6, 6, 1);
    wait_cycles(17);
    start_s[0] = 1'b0;
    wait_cycles(10);
    // abort during round 5 of p^a
    c = cyc;
    kick(0, 1'b0);
    expect_run(0, c, 12, 5, 0);
    tick();
    start_s[0] = 1'b0;
    wait_cycles(4);
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    wait_cycles(4);
    // abort together with start in IDLE
    kick(0, 1'b0);
    abort_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    wait_cycles(4);
    // abort in the final round suppresses done
    c = cyc;
    kick(0, 1'b1);
    expect_run(0, c, 6, 6, 0);
    tick();
    start_s[0] = 1'b0;
    wait_cycles(5);
    abort_s[0] = 1'b1;
    tick();
    abort_s[0] = 1'b0;
    wait_cycles(4);
    // asynchronous reset in round 3
    c = cyc;
    kick(0, 1'b0);
    expect_run(0, c, 12, 3, 0);
    tick();
    start_s[0] = 1'b0;
    wait_cycles(2);
    #2 resetb = 1'b0;
    #1;
    nvec++;
    if (obs(0) != 16'h0) begin
      nerr++;
      $display("FAIL async_reset got %h required 0000", obs(0));
    end
    wait_cycles(2);
    resetb = 1'b1;
    wait_cycles(2);
    c = cyc;
    kick(0, 1'b0);
    expect_run(0, c, 12, 12, 1);
    tick();
    start_s[0] = 1'b0;
    wait_cycles(16);
    for (int d = 0; d < 3; d++) begin
      nvec++;
      if (q[d].size() != 0) begin
        nerr++;
        $display("FAIL missing_outputs dut%0d got %0d pending required 0", d, q[d].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
